// File: rtl/text_render_pipe.sv
// Pipelined text-mode pixel generator: VGA position -> VRAM word -> font row -> RGB444.
// Three register stages; sync/blank outputs are delayed to line up with the pixel data.
module text_render_pipe #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int VRAM_AW      = 10,
    parameter int BLINK_FRAMES = 30,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         draw_x,
    input  logic [9:0]         draw_y,
    input  logic               vde_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic [31:0]        vram_data,
    output logic [10:0]        font_addr,
    input  logic [7:0]         font_data,
    input  logic [11:0]        fg_color,
    input  logic [11:0]        bg_color,
    input  logic               cursor_en,
    input  logic [6:0]         cursor_col,
    input  logic [4:0]         cursor_row,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               vde_out
);

    localparam int IDX_W = VRAM_AW + 2;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    function automatic logic pixel_on(input logic [7:0] row_bits, input logic [2:0] x_off,
                                      input logic inv, input logic cursor_vis);
        pixel_on = row_bits[3'd7 - x_off] ^ inv ^ cursor_vis;
    endfunction

    function automatic logic [11:0] pick_color(input logic on, input logic visible,
                                               input logic [11:0] fg, input logic [11:0] bg);
        if (!visible)
            pick_color = 12'h000;
        else
            pick_color = on ? fg : bg;
    endfunction

    // Stage 0: character-cell address generation
    logic [6:0]       col_s;
    logic [5:0]       row_s;
    logic [IDX_W-1:0] idx_s;
    logic             in_range_s;
    logic             cursor_hit_s;
    logic [VRAM_AW-1:0] vram_addr_d, vram_addr_q;
    logic [1:0]       byte_sel_p0_q;
    logic [3:0]       y_off_p0_q;
    logic [2:0]       x_off_p0_q;
    logic             in_range_p0_q;
    logic             hit_p0_q;

    always_comb begin
        col_s        = draw_x[9:3];
        row_s        = draw_y[9:4];
        idx_s        = IDX_W'(int'(row_s) * COLS + int'(col_s));
        in_range_s   = (int'(draw_x) < H_ACTIVE) && (int'(draw_y) < V_ACTIVE);
        cursor_hit_s = cursor_en && (col_s == cursor_col) && (row_s == {1'b0, cursor_row});
        vram_addr_d  = in_range_s ? idx_s[IDX_W-1:2] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vram_addr_q   <= '0;
            byte_sel_p0_q <= '0;
            y_off_p0_q    <= '0;
            x_off_p0_q    <= '0;
            in_range_p0_q <= 1'b0;
            hit_p0_q      <= 1'b0;
        end else begin
            vram_addr_q   <= vram_addr_d;
            byte_sel_p0_q <= idx_s[1:0];
            y_off_p0_q    <= draw_y[3:0];
            x_off_p0_q    <= draw_x[2:0];
            in_range_p0_q <= in_range_s;
            hit_p0_q      <= cursor_hit_s;
        end
    end

    // Stage 1: glyph byte select and font row addressing
    logic [7:0]  code_s;
    logic [10:0] font_addr_d, font_addr_q;
    logic        inv_p1_q;
    logic [2:0]  x_off_p1_q;
    logic        in_range_p1_q;
    logic        hit_p1_q;

    always_comb begin
        code_s      = 8'(vram_data >> {byte_sel_p0_q, 3'b000});
        font_addr_d = in_range_p0_q ? {code_s[6:0], y_off_p0_q} : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            font_addr_q   <= '0;
            inv_p1_q      <= 1'b0;
            x_off_p1_q    <= '0;
            in_range_p1_q <= 1'b0;
            hit_p1_q      <= 1'b0;
        end else begin
            font_addr_q   <= font_addr_d;
            inv_p1_q      <= code_s[7];
            x_off_p1_q    <= x_off_p0_q;
            in_range_p1_q <= in_range_p0_q;
            hit_p1_q      <= hit_p0_q;
        end
    end

    // Sync shift register, bit order {hsync, vsync, vde}
    logic [2:0] sync_p0_q, sync_p1_q, sync_p2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0_q <= '0;
            sync_p1_q <= '0;
            sync_p2_q <= '0;
        end else begin
            sync_p0_q <= {hsync_in, vsync_in, vde_in};
            sync_p1_q <= sync_p0_q;
            sync_p2_q <= sync_p1_q;
        end
    end

    // Blink timer: sync_p0_q[1] is the registered vsync, sync_p1_q[1] its previous value
    logic            frame_tick_s;
    logic [FC_W-1:0] frame_cnt_d, frame_cnt_q;
    logic            blink_phase_d, blink_phase_q;

    always_comb begin
        frame_tick_s  = sync_p0_q[1] & ~sync_p1_q[1];
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_tick_s) begin
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // Stage 2: pixel decision and colour output
    logic        on_s;
    logic [11:0] rgb_d, rgb_q;

    always_comb begin
        on_s  = pixel_on(font_data, x_off_p1_q, inv_p1_q, hit_p1_q & blink_phase_q);
        rgb_d = pick_color(on_s, in_range_p1_q & sync_p1_q[0], fg_color, bg_color);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rgb_q <= '0;
        else
            rgb_q <= rgb_d;
    end

    assign vram_addr = vram_addr_q;
    assign font_addr = font_addr_q;
    assign red       = rgb_q[11:8];
    assign green     = rgb_q[7:4];
    assign blue      = rgb_q[3:0];
    assign hsync_out = sync_p2_q[2];
    assign vsync_out = sync_p2_q[1];
    assign vde_out   = sync_p2_q[0];

endmodule

// File: doc/text_render_pipe.md
Name: text_render_pipe

Overview:
- Pipelined successor to the combinational text-mode pixel generator in the HDMI text controller.
- Takes the VGA timing position plus sync/blank signals and issues registered addresses to a synchronous VRAM and font ROM (1-cycle read latency each).
- Produces registered RGB444 with sync signals delay-matched.
- Adds runtime fg/bg colours, per-glyph inverse, a blinking hardware cursor, parametrised text geometry, and a corrected MSB-leftmost font bit order.

Parameters:
- COLS, 80, text columns; must be a multiple of 4.
- ROWS, 30, text rows.
- VRAM_AW, 10, VRAM word-address width; must satisfy 2^VRAM_AW >= COLS*ROWS/4.
- BLINK_FRAMES, 30, frames per cursor blink half-period, >= 1.
- H_ACTIVE, 640, active pixels per line; must equal COLS*8.
- V_ACTIVE, 480, active lines; must equal ROWS*16.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- draw_x  in  10  current pixel column
- draw_y  in  10  current pixel row
- vde_in  in  1  video data enable from timing generator
- hsync_in  in  1  horizontal sync from timing generator
- vsync_in  in  1  vertical sync from timing generator
- vram_addr  out  VRAM_AW  word address to VRAM (4 glyph bytes per 32-bit word)
- vram_data  in  32  VRAM read data, valid 1 cycle after vram_addr
- font_addr  out  11  font ROM address
- font_data  in  8  font ROM row data, valid 1 cycle after font_addr
- fg_color  in  12  foreground colour {R,G,B}; quasi-static
- bg_color  in  12  background colour {R,G,B}; quasi-static
- cursor_en  in  1  cursor enable
- cursor_col  in  7  cursor column
- cursor_row  in  5  cursor row
- red  out  4  pixel red
- green  out  4  pixel green
- blue  out  4  pixel blue
- hsync_out  out  1  hsync_in delayed 3 cycles
- vsync_out  out  1  vsync_in delayed 3 cycles
- vde_out  out  1  vde_in delayed 3 cycles

Behaviour:
- All outputs and pipeline registers reset asynchronously to 0, except blink_phase, which resets to 1 (cursor visible).
- Pipeline, 3 cycles total from draw_x/draw_y/syncs to RGB/sync outputs:
  - S0 (register at edge N):
    - col = draw_x>>3, row = draw_y>>4, idx = row*COLS + col.
    - vram_addr <= idx>>2.
    - Carry byte_sel = idx[1:0], y_off = draw_y[3:0], x_off = draw_x[2:0], in_range, cursor_hit.
    - in_range = draw_x < H_ACTIVE and draw_y < V_ACTIVE.
    - cursor_hit = cursor_en and col==cursor_col and row==cursor_row.
    - If not in_range, vram_addr <= 0.
  - S1 (edge N+1):
    - code = vram_data[byte_sel*8 +: 8].
    - font_addr <= {code[6:0], y_off}.
    - Carry inv = code[7], x_off, in_range, cursor_hit.
    - font_addr <= 0 if not in_range.
  - S2 (edge N+2):
    - bit = font_data[7 - x_off]; MSB is the leftmost pixel.
    - on = bit XOR inv XOR (cursor_hit AND blink_phase).
    - RGB <= on ? fg_color : bg_color when in_range and vde; otherwise RGB <= 0.
- hsync/vsync/vde pass through a 3-stage shift register aligned with RGB.
- Blink logic:
  - vsync_in is registered; a rising edge of the registered value is a frame tick.
  - frame_cnt counts ticks 0..BLINK_FRAMES-1.
  - On a tick with frame_cnt == BLINK_FRAMES-1: frame_cnt <= 0 and blink_phase toggles.
  - BLINK_FRAMES = 1 toggles every frame.
- fg_color/bg_color/cursor inputs are sampled directly with no CDC; the driver changes them only as quasi-static registers.
- Reset mid-frame: pipeline flushes to 0, so output is black with syncs low for 3 cycles after release.
- Boundary: draw_x = H_ACTIVE-1 and draw_y = V_ACTIVE-1 address the last word, (COLS*ROWS/4)-1.

Test Plan:
- Reset asserted mid-line -> red/green/blue/hsync_out/vsync_out/vde_out are 0 immediately (asynchronously); blink_phase = 1.
- VRAM word 0 = 0x00410041, font row for 'A' (0x41) y=0 = 0x18, fg=0xFFF, bg=0x000, vde=1, draw_y=0, draw_x=0..7 -> vram_addr=0 at N+1, font_addr=0x410 at N+2, RGB sequence 0,0,0,F,F,0,0,0 (per channel) appearing at cycles 3..10.
- Byte 3 of word 0 = 0xC1 (inverse 'A'), draw_x=24..31 -> pixels are the complement of the above pattern; byte_sel=3 verified.
- Cursor at (col 2, row 1), cursor_en=1, BLINK_FRAMES=2, space glyph (all-zero font) -> cell shows fg for frames 0-1, bg for frames 2-3, fg for frames 4-5; other cells show bg throughout.
- draw_x=640 or draw_y=480 with vde=0 -> vram_addr=0, RGB=0; hsync/vsync toggles reproduced exactly 3 cycles later.
- draw_x=639, draw_y=479 -> vram_addr=599, byte_sel=3, font_addr row offset 15.
